// File: rtl/rcn_master_arb.sv
// rcn_master_arb
//   Round-robin arbiter sharing one rcn_master between four local requesters.
//   The requester index travels in the rcn seq field, so responses are routed
//   back by m_rsp_seq alone. Each port may have one transaction outstanding;
//   a per-port wait counter releases a port whose response never returns.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   p_req/p_wr        per-port request level (held until p_ack) / write flag
//   p_mask/p_addr/    per-port packed fields, port i at [4i+:4], [22i+:22],
//   p_wdata           [32i+:32]
//   p_ack             request accepted by rcn_master (one-cycle pulse)
//   p_rdone/p_wdone   read / write response for the port (one-cycle pulse)
//   p_err             wait timeout, port released (one-cycle pulse)
//   rsp_addr/rsp_data response pass-through, valid alongside a done pulse
//   m_cs..m_wdata     request side of rcn_master (registered)
//   m_busy            rcn_master cannot take the request this cycle
//   m_rdone/m_wdone/  response side of rcn_master
//   m_rsp_seq/addr/data
//
// Parameter
//   TIMEOUT           cycles a port may wait for its response; 0 disables,
//                     maximum 65535
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | no request presented; picks the next eligible port round-robin
// ISSUE | held request driven on m_*; leaves when m_busy is low (accept)

module rcn_master_arb #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,

  input  logic [3:0]   p_req,
  input  logic [3:0]   p_wr,
  input  logic [15:0]  p_mask,
  input  logic [87:0]  p_addr,
  input  logic [127:0] p_wdata,
  output logic [3:0]   p_ack,
  output logic [3:0]   p_rdone,
  output logic [3:0]   p_wdone,
  output logic [3:0]   p_err,
  output logic [21:0]  rsp_addr,
  output logic [31:0]  rsp_data,

  output logic         m_cs,
  output logic [1:0]   m_seq,
  output logic         m_wr,
  output logic [3:0]   m_mask,
  output logic [21:0]  m_addr,
  output logic [31:0]  m_wdata,
  input  logic         m_busy,
  input  logic         m_rdone,
  input  logic         m_wdone,
  input  logic [1:0]   m_rsp_seq,
  input  logic [21:0]  m_rsp_addr,
  input  logic [31:0]  m_rsp_data
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam bit          TO_EN   = (TIMEOUT != 0);
  // Counter is cleared at accept, so it reads TIMEOUT-1 in the TIMEOUT-th
  // cycle after p_ack.
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

  state_t       state_q, state_d;
  logic [1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]   pending_q, pending_d;

  logic [1:0]   hold_port_q, hold_port_d;
  logic         hold_wr_q, hold_wr_d;
  logic [3:0]   hold_mask_q, hold_mask_d;
  logic [21:0]  hold_addr_q, hold_addr_d;
  logic [31:0]  hold_wdata_q, hold_wdata_d;

  logic [15:0]  cnt_q [4];
  logic [15:0]  cnt_d [4];

  logic [3:0]   eligible;
  logic         any_eligible;
  logic [1:0]   grant_idx;
  logic         capture;
  logic         accept;
  logic [3:0]   seq_hit;
  logic [3:0]   timeout_hit;

  // Eligibility uses the registered pending bits, so a port released by a
  // done/err pulse competes again only from the following cycle.
  assign eligible     = p_req & ~pending_q;
  assign any_eligible = |eligible;

  // First eligible port at or above rr_ptr, modulo 4. Scanning offsets from
  // the far end down lets the nearest one overwrite the result last.
  always_comb begin
    grant_idx = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (eligible[rr_ptr_q + 2'(k)]) begin
        grant_idx = rr_ptr_q + 2'(k);
      end
    end
  end

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_eligible) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!m_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    m_cs    = 1'b0;
    capture = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        capture = any_eligible;
      end
      ISSUE: begin
        m_cs   = 1'b1;
        accept = !m_busy;
      end
      default: begin
        m_cs = 1'b0;
      end
    endcase
  end

  assign p_ack   = accept ? (4'b0001 << hold_port_q) : 4'b0000;

  assign m_seq   = hold_port_q;
  assign m_wr    = hold_wr_q;
  assign m_mask  = hold_mask_q;
  assign m_addr  = hold_addr_q;
  assign m_wdata = hold_wdata_q;

  // ------------------------------------------------------------------
  // Hold register: loaded at grant, frozen through ISSUE so requester
  // changes after the grant do not reach rcn_master.
  // ------------------------------------------------------------------
  always_comb begin
    hold_port_d  = hold_port_q;
    hold_wr_d    = hold_wr_q;
    hold_mask_d  = hold_mask_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    if (capture) begin
      hold_port_d  = grant_idx;
      hold_wr_d    = p_wr[grant_idx];
      hold_mask_d  = p_mask[{grant_idx, 2'b00} +: 4];
      hold_addr_d  = p_addr[22 * grant_idx +: 22];
      hold_wdata_d = p_wdata[{grant_idx, 5'b00000} +: 32];
    end
  end

  assign rr_ptr_d = accept ? (hold_port_q + 2'd1) : rr_ptr_q;

  // ------------------------------------------------------------------
  // Response routing and timeout. Responses for ports that are not
  // pending (stray, or late after a timeout) fall out here with no effect.
  // ------------------------------------------------------------------
  always_comb begin
    seq_hit     = 4'b0000;
    p_rdone     = 4'b0000;
    p_wdone     = 4'b0000;
    timeout_hit = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      seq_hit[i]     = pending_q[i] && (m_rsp_seq == 2'(i));
      p_rdone[i]     = m_rdone && seq_hit[i];
      p_wdone[i]     = m_wdone && seq_hit[i];
      // A response landing on the last wait cycle takes priority.
      timeout_hit[i] = TO_EN && pending_q[i] && (cnt_q[i] == TO_LAST) &&
                       !(p_rdone[i] || p_wdone[i]);
    end
  end

  assign p_err     = timeout_hit;
  assign pending_d = (pending_q & ~(p_rdone | p_wdone | p_err)) | p_ack;

  assign rsp_addr  = m_rsp_addr;
  assign rsp_data  = m_rsp_data;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (p_ack[i]) begin
        cnt_d[i] = 16'd0;
      end else if (TO_EN && pending_q[i]) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= 2'd0;
      pending_q    <= 4'b0000;
      hold_port_q  <= 2'd0;
      hold_wr_q    <= 1'b0;
      hold_mask_q  <= 4'd0;
      hold_addr_q  <= 22'd0;
      hold_wdata_q <= 32'd0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 16'd0;
      end
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      pending_q    <= pending_d;
      hold_port_q  <= hold_port_d;
      hold_wr_q    <= hold_wr_d;
      hold_mask_q  <= hold_mask_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rcn_master_arb.sv
// Testbench for rcn_master_arb with TIMEOUT=8. A transaction-level model of
// the arbiter (outstanding set, ages since acceptance, round-robin pointer)
// predicts every output each cycle; directed scenarios add explicit checks.

module tb_rcn_master_arb;

  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   p_req = '0;
  logic [3:0]   p_wr = '0;
  logic [15:0]  p_mask = '0;
  logic [87:0]  p_addr = '0;
  logic [127:0] p_wdata = '0;
  logic [3:0]   p_ack, p_rdone, p_wdone, p_err;
  logic [21:0]  rsp_addr;
  logic [31:0]  rsp_data;
  logic         m_cs, m_wr;
  logic [1:0]   m_seq;
  logic [3:0]   m_mask;
  logic [21:0]  m_addr;
  logic [31:0]  m_wdata;
  logic         m_busy = 1'b0;
  logic         m_rdone = 1'b0;
  logic         m_wdone = 1'b0;
  logic [1:0]   m_rsp_seq = '0;
  logic [21:0]  m_rsp_addr = '0;
  logic [31:0]  m_rsp_data = '0;

  rcn_master_arb #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_wr(p_wr), .p_mask(p_mask), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_ack(p_ack), .p_rdone(p_rdone), .p_wdone(p_wdone), .p_err(p_err),
    .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .m_cs(m_cs), .m_seq(m_seq), .m_wr(m_wr), .m_mask(m_mask), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_busy(m_busy), .m_rdone(m_rdone), .m_wdone(m_wdone),
    .m_rsp_seq(m_rsp_seq), .m_rsp_addr(m_rsp_addr), .m_rsp_data(m_rsp_data)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: which request is being presented, which ports have a
  // transaction outstanding and how many cycles ago it was accepted.
  bit          mdl_issue;
  logic [1:0]  mdl_port;
  logic        mdl_wr;
  logic [3:0]  mdl_mask;
  logic [21:0] mdl_addr;
  logic [31:0] mdl_wdata;
  int          mdl_rr;
  bit   [3:0]  mdl_pend;
  int          mdl_age [4];
  logic [3:0]  e_ack, e_rd, e_wd, e_err, obs_ack;
  bit          acc_valid;
  int          acc_port;
  bit          acc_wr;
  logic [3:0]  keep_req = '0;

  task automatic model_reset();
    mdl_issue = 0; mdl_port = '0; mdl_wr = 1'b0; mdl_mask = '0; mdl_addr = '0;
    mdl_wdata = '0; mdl_rr = 0; mdl_pend = '0; acc_valid = 0;
    for (int i = 0; i < 4; i++) mdl_age[i] = 0;
  endtask

  task automatic compare_all();
    logic [61:0] exp_req;
    e_ack = (mdl_issue && !m_busy) ? (4'b0001 << mdl_port) : 4'b0000;
    for (int i = 0; i < 4; i++) begin
      e_rd[i]  = mdl_pend[i] && (int'(m_rsp_seq) == i) && m_rdone;
      e_wd[i]  = mdl_pend[i] && (int'(m_rsp_seq) == i) && m_wdone;
      e_err[i] = mdl_pend[i] && (mdl_age[i] == TMO) && !(e_rd[i] || e_wd[i]);
    end
    exp_req = {mdl_issue, mdl_port, mdl_wr, mdl_mask, mdl_addr, mdl_wdata};
    check("req_port", 64'({m_cs, m_seq, m_wr, m_mask, m_addr, m_wdata}), 64'(exp_req));
    check("pulses", 64'({p_ack, p_rdone, p_wdone, p_err}), 64'({e_ack, e_rd, e_wd, e_err}));
    check("rsp_pass", 64'({rsp_addr, rsp_data}), 64'({m_rsp_addr, m_rsp_data}));
    obs_ack = p_ack;
  endtask

  task automatic model_step();
    bit [3:0] elig;
    int j;
    elig = p_req & ~mdl_pend;
    acc_valid = 0;
    for (int i = 0; i < 4; i++) if (mdl_pend[i]) mdl_age[i]++;
    mdl_pend &= ~(e_rd | e_wd | e_err);
    if (mdl_issue) begin
      if (!m_busy) begin
        mdl_pend[mdl_port] = 1'b1;
        mdl_age[mdl_port]  = 1;
        mdl_rr    = (int'(mdl_port) + 1) % 4;
        mdl_issue = 0;
        acc_valid = 1; acc_port = int'(mdl_port); acc_wr = mdl_wr;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        j = (mdl_rr + k) % 4;
        if (elig[j]) begin
          mdl_issue = 1;
          mdl_port  = 2'(j);
          mdl_wr    = p_wr[j];
          mdl_mask  = p_mask[4*j +: 4];
          mdl_addr  = p_addr[22*j +: 22];
          mdl_wdata = p_wdata[32*j +: 32];
          break;
        end
      end
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model at the
  // rising edge, then retire one-cycle response inputs and acked requests.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    m_rdone = 1'b0;
    m_wdone = 1'b0;
    p_req = p_req & ~(e_ack & ~keep_req);
  endtask

  task automatic set_port(input int i, input bit wr, input logic [3:0] mask,
                          input logic [21:0] addr, input logic [31:0] wd);
    p_req[i] = 1'b1;
    p_wr[i]  = wr;
    p_mask[4*i +: 4]    = mask;
    p_addr[22*i +: 22]  = addr;
    p_wdata[32*i +: 32] = wd;
  endtask

  task automatic respond(input int port, input bit wr, input logic [31:0] data);
    m_rsp_seq  = 2'(port);
    m_rsp_data = data;
    m_rsp_addr = 22'(port * 4);
    if (wr) m_wdone = 1'b1; else m_rdone = 1'b1;
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    oh_idx = -1;
    for (int i = 0; i < 4; i++) if (v[i]) oh_idx = i;
  endfunction

  int grants[$];
  int q_port[$];
  bit q_wr[$];
  int q_due[$];
  int n0, n3;

  initial begin
    model_reset();

    // ---------------- reset state
    repeat (3) tick();
    #1;
    check("rst_cs", 64'(m_cs), 64'(0));
    check("rst_pulses", 64'({p_ack, p_rdone, p_wdone, p_err}), 64'(0));
    rst = 1'b0;

    // ---------------- single read, port 2
    set_port(2, 1'b0, 4'hF, 22'h00123C, 32'h0);
    tick();
    #1;
    check("rd_cs", 64'(m_cs), 64'(1));
    check("rd_seq", 64'(m_seq), 64'(2));
    check("rd_addr", 64'(m_addr), 64'(22'h00123C));
    check("rd_ack", 64'(p_ack), 64'(4'b0100));
    tick();
    respond(2, 1'b0, 32'hDEADBEEF);
    #1;
    check("rd_done", 64'(p_rdone), 64'(4'b0100));
    check("rd_data", 64'(rsp_data), 64'(32'hDEADBEEF));
    tick();
    #1;
    check("rd_done_once", 64'(p_rdone), 64'(0));
    tick();

    // ---------------- busy stall, port 1 write
    set_port(1, 1'b1, 4'h3, 22'h2AAAA, 32'h12345678);
    m_busy = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_req", 64'({m_cs, m_seq, m_wr, m_mask, m_addr, m_wdata}),
            64'({1'b1, 2'd1, 1'b1, 4'h3, 22'h2AAAA, 32'h12345678}));
      check("stall_ack", 64'(p_ack), 64'(0));
      p_addr[22 +: 22] = 22'h155;
      tick();
    end
    m_busy = 1'b0;
    #1;
    check("stall_ack_drop", 64'(p_ack), 64'(4'b0010));
    tick();
    respond(1, 1'b1, 32'h0);
    #1;
    check("stall_wdone", 64'(p_wdone), 64'(4'b0010));
    tick();
    tick();

    // ---------------- timeout, port 1
    set_port(1, 1'b0, 4'hF, 22'h000111, 32'h0);
    tick();
    #1;
    check("to_ack", 64'(p_ack), 64'(4'b0010));
    tick();
    for (int k = 1; k < TMO; k++) begin
      #1;
      check("to_no_err_early", 64'(p_err), 64'(0));
      tick();
    end
    #1;
    check("to_err", 64'(p_err), 64'(4'b0010));
    set_port(1, 1'b0, 4'hF, 22'h000222, 32'h0);
    tick();
    respond(1, 1'b0, 32'hCAFE0001);
    #1;
    check("to_late_rd", 64'({p_rdone, p_wdone, p_err}), 64'(0));
    tick();
    #1;
    check("to_regrant", 64'({m_cs, m_seq, m_addr}), 64'({1'b1, 2'd1, 22'h000222}));
    tick();
    respond(1, 1'b0, 32'hCAFE0002);
    #1;
    check("to_regrant_done", 64'(p_rdone), 64'(4'b0010));
    tick();

    // ---------------- response and timeout in the same cycle, port 0
    set_port(0, 1'b0, 4'hF, 22'h000400, 32'h0);
    tick();
    tick();
    for (int k = 1; k < TMO; k++) tick();
    respond(0, 1'b0, 32'h0BADF00D);
    #1;
    check("race_rdone", 64'(p_rdone), 64'(4'b0001));
    check("race_no_err", 64'(p_err), 64'(0));
    tick();

    // ---------------- one outstanding per port
    keep_req = 4'b0001;
    set_port(0, 1'b1, 4'h1, 22'h000AB0, 32'hA5A5A5A5);
    set_port(3, 1'b0, 4'hF, 22'h3FFFFC, 32'h0);
    n0 = 0; n3 = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      n0 += int'(p_ack[0]); n3 += int'(p_ack[3]);
      tick();
    end
    check("one_out_p0", 64'(n0), 64'(1));
    check("one_out_p3", 64'(n3), 64'(1));
    respond(0, 1'b1, 32'h0);
    #1;
    check("one_out_wdone", 64'(p_wdone), 64'(4'b0001));
    tick();
    n0 = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n0 += int'(p_ack[0]);
      tick();
    end
    check("one_out_regrant", 64'(n0), 64'(1));
    keep_req = '0;
    p_req = '0;
    repeat (10) tick();

    // ---------------- reset mid-operation
    set_port(0, 1'b0, 4'hF, 22'h000001, 32'h0);
    tick();
    tick();
    set_port(2, 1'b1, 4'hF, 22'h000002, 32'h5);
    m_busy = 1'b1;
    tick();
    #1;
    check("rst_mid_cs_before", 64'(m_cs), 64'(1));
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_mid_cs", 64'(m_cs), 64'(0));
    m_busy = 1'b0;
    p_req = '0;
    tick();
    rst = 1'b0;
    respond(0, 1'b0, 32'h77777777);
    #1;
    check("rst_mid_drop", 64'({p_rdone, p_wdone, p_err}), 64'(0));
    tick();

    // ---------------- fairness: all ports requesting, immediate responses
    keep_req = 4'hF;
    for (int i = 0; i < 4; i++) set_port(i, i[0], 4'(i), 22'(i + 16), 32'(i));
    for (int c = 0; c < 26; c++) begin
      if (acc_valid) respond(acc_port, acc_wr, 32'(c));
      tick();
      if (obs_ack != 4'b0000) grants.push_back(oh_idx(obs_ack));
    end
    check("fair_count", 64'(grants.size() >= 12), 64'(1));
    for (int k = 0; k < 12 && k < grants.size(); k++)
      check("fair_order", 64'(grants[k]), 64'(k % 4));
    keep_req = '0;
    p_req = '0;
    if (acc_valid) respond(acc_port, acc_wr, 32'h0);
    repeat (12) tick();

    // ---------------- randomized traffic
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++)
        if (!p_req[i] && $urandom_range(0, 2) == 0)
          set_port(i, 1'($urandom), 4'($urandom), 22'($urandom), $urandom);
      m_busy     = ($urandom_range(0, 3) == 0);
      m_rsp_seq  = 2'($urandom);
      m_rsp_addr = 22'($urandom);
      m_rsp_data = $urandom;
      if (q_due.size() > 0 && q_due[0] <= c) begin
        if (q_wr[0]) m_wdone = 1'b1; else m_rdone = 1'b1;
        m_rsp_seq = 2'(q_port[0]);
        void'(q_port.pop_front()); void'(q_wr.pop_front()); void'(q_due.pop_front());
      end else if ($urandom_range(0, 19) == 0) begin
        m_rdone = 1'b1;
      end
      tick();
      if (acc_valid) begin
        q_port.push_back(acc_port);
        q_wr.push_back(acc_wr);
        q_due.push_back(c + int'($urandom_range(1, 10)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rcn_master_arb.md
# rcn_master_arb

Four-port round-robin arbiter that shares one `rcn_master` between up to four local requesters. The requester index is carried in the rcn `seq` field, so responses are routed back by `rsp_seq` without a tag table. Each port may have one transaction in flight; a per-port timeout recovers ports whose response never returns. Sits directly between local bus clients and the `rcn_master` request/response ports.

## Interface
- `TIMEOUT`, default 1024: cycles a port may wait for its response before the arbiter abandons it; 0 disables the timeout; maximum 65535.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `p_req`  in  4  per-port request level; held until `p_ack[i]`.
- `p_wr`  in  4  per-port write (1) / read (0).
- `p_mask`  in  16  per-port byte mask; port i uses bits [4i+3:4i].
- `p_addr`  in  88  per-port address; port i uses bits [22i+21:22i].
- `p_wdata`  in  128  per-port write data; port i uses bits [32i+31:32i].
- `p_ack`  out  4  one-cycle pulse: the request was accepted by `rcn_master`.
- `p_rdone`  out  4  one-cycle pulse: read response for the port.
- `p_wdone`  out  4  one-cycle pulse: write response for the port.
- `p_err`  out  4  one-cycle pulse: timeout, the port is released.
- `rsp_addr`  out  22  pass-through of `m_rsp_addr`.
- `rsp_data`  out  32  pass-through of `m_rsp_data`.
- `m_cs`  out  1  to `rcn_master` `cs`.
- `m_seq`  out  2  to `rcn_master` `seq`.
- `m_wr`  out  1  to `rcn_master` `wr`.
- `m_mask`  out  4  to `rcn_master` `mask`.
- `m_addr`  out  22  to `rcn_master` `addr`.
- `m_wdata`  out  32  to `rcn_master` `wdata`.
- `m_busy`  in  1  from `rcn_master`.
- `m_rdone`  in  1  from `rcn_master`.
- `m_wdone`  in  1  from `rcn_master`.
- `m_rsp_seq`  in  2  from `rcn_master`.
- `m_rsp_addr`  in  22  from `rcn_master`.
- `m_rsp_data`  in  32  from `rcn_master`.

## Operation
- State: FSM {IDLE, ISSUE}; `rr_ptr[1:0]`; `pending[3:0]`; hold register (port, wr, mask, addr, wdata); four 16-bit wait counters.
- Eligible ports: `p_req & ~pending`, using the registered `pending`.
- IDLE:
  - If any port is eligible, grant the first eligible port searching from `rr_ptr` upward, modulo 4.
  - Capture the granted port's fields into the hold register and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - Drive `m_cs`=1 and `m_seq`=held port index; `m_wr/m_mask/m_addr/m_wdata` come from the hold register.
  - Accept condition: `m_busy`=0. In the accept cycle, `p_ack[port]`=1 (combinational), `pending[port]` is set, the port's counter is cleared, `rr_ptr`=port+1, and the FSM returns to IDLE.
  - While `m_busy`=1: hold everything, stay in ISSUE. Requester changes after the grant are ignored.
- Response decode:
  - `p_rdone[i] = m_rdone & (m_rsp_seq==i) & pending[i]`; `p_wdone[i]` likewise with `m_wdone`.
  - On either pulse, `pending[i]` clears at the next edge.
- A response for a port with `pending`=0 (late after timeout, or stray) is dropped: no pulse, no state change.
- Timeout, when `TIMEOUT`≠0:
  - The counter increments each cycle while `pending[i]`=1.
  - When the counter equals `TIMEOUT-1` and no response arrives that cycle, `p_err[i]`=1 and `pending[i]` clears.
  - A response and a timeout in the same cycle: the response wins and `p_err` is not asserted.
- `m_rsp_addr`/`m_rsp_data` pass straight to `rsp_addr`/`rsp_data`, valid only alongside a done pulse.

## Timing
- Reset values:
  - FSM=IDLE; `rr_ptr`=0; `pending`=0; counters=0; hold register=0.
  - `m_cs`=0, `m_seq`=0, `m_wr`=0, `m_mask`=0, `m_addr`=0, `m_wdata`=0.
  - `p_ack`/`p_rdone`/`p_wdone`/`p_err`=0.
  - `rsp_*` follow their inputs.
- Reset asserted mid-ISSUE: `m_cs` drops immediately (asynchronous); all in-flight state is lost; later responses are dropped because `pending`=0.
- Grant latency:
  - Request seen in IDLE at cycle N → `m_cs`=1 at cycle N+1.
  - `p_ack` in the first cycle ≥N+1 with `m_busy`=0.
- Issue rate: at most one accepted request per 2 cycles, since IDLE lasts at least 1 cycle between grants.
- A port becomes eligible again the cycle after its done or err pulse.
- `m_cs` and the `m_*` request fields are registered. `p_ack`, `p_rdone`, `p_wdone` and `p_err` are combinational from registered state and the current `m_*` inputs.

## Test plan
- Single read:
  - Stimulus: port 2, addr 0x00123C, `m_busy`=0.
  - Required: `m_cs` asserted 1 cycle after `p_req`, `m_seq`=2, `p_ack[2]` in the same cycle.
  - Then a response with `m_rsp_seq`=2, `m_rdone`=1 and data 0xDEADBEEF gives exactly one `p_rdone[2]` pulse with `rsp_data`=0xDEADBEEF.
- Fairness: all 4 ports request continuously with immediate responses → grant order 0,1,2,3,0,…; no port is granted twice before every other port is granted once.
- Busy stall: hold `m_busy`=1 for 5 cycles during ISSUE → `m_cs` and the `m_*` fields stay stable for all 5 cycles; `p_ack` pulses only in the cycle `m_busy` drops.
- Timeout:
  - Stimulus: `TIMEOUT`=8, port 1 issued, no response.
  - Required: `p_err[1]` pulses in the 8th cycle after `p_ack[1]`; port 1 is re-grantable the following cycle.
  - A later response with `m_rsp_seq`=1 produces no `p_rdone`/`p_wdone`.
- One outstanding per port: port 0 issues and keeps `p_req` high → no second grant until its `p_wdone[0]`; meanwhile port 3 is granted normally.
- Reset mid-operation: assert `rst` while `m_cs`=1 → `m_cs`=0 immediately, `pending`=0, and a response arriving after reset is dropped.
